// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the framed UART image transmitter.
// State encoding, character geometry and pixel byte slice.
package uart_frame_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_BITS = 10;
    localparam int PIX_BYTE_MSB    = 11;
    localparam int PIX_BYTE_LSB    = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        FETCH,
        LOAD,
        SEND,
        CKSUM,
        DONE
    } state_t;

    // Trailer value that makes payload + trailer sum to zero mod 256.
    function automatic logic [UART_DATA_W-1:0] cksum_trailer(
        input logic [UART_DATA_W-1:0] sum
    );
        return UART_DATA_W'(~sum + 1'b1);
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 character serializer: start bit, 8 data bits LSB first, stop bit.
// Every bit lasts CLK_FREQ/UART_BPS clocks; char_done pulses after the stop bit.
module uart_tx_serializer
    import uart_frame_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [UART_DATA_W-1:0] data,
    output logic                   tx,
    output logic                   ready,
    output logic                   char_done
);

    localparam int BIT_CYC = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [3:0] IDX_LAST = 4'(UART_FRAME_BITS - 1);

    logic                   r_tx;
    logic                   r_busy;
    logic                   r_done;
    logic [CNT_W-1:0]       r_cnt;
    logic [3:0]             r_idx;
    logic [UART_DATA_W:0]   r_shift;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '1;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (load) begin
                    r_busy  <= 1'b1;
                    r_tx    <= 1'b0;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_shift <= {1'b1, data};
                end
            end else if (r_cnt != CNT_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
                if (r_idx == IDX_LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_tx   <= 1'b1;
                end else begin
                    // Shift in ones so the stop bit falls out last.
                    r_idx   <= r_idx + 4'd1;
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[UART_DATA_W:1]};
                end
            end
        end
    end

    assign tx        = r_tx;
    assign ready     = ~r_busy;
    assign char_done = r_done;

endmodule

// File: rtl/uart_frame_tx.sv
// Framed, abortable UART frame transmitter: sync header, pixel payload, optional trailer.
// Define UART_FRAME_CKSUM_EN to append a two's-complement checksum character.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int          CLK_FREQ    = 50_000_000,
    parameter int          UART_BPS    = 115200,
    parameter logic [19:0] FRAME_BYTES = 20'h4B000,
    parameter logic [15:0] SYNC_WORD   = 16'hA55A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        pix_rd,
    input  logic [11:0] pix_data,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [19:0] byte_count
);

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pix_rd;
    logic                   r_load;
    logic [UART_DATA_W-1:0] r_data;
    logic [19:0]            r_count;
    logic                   r_abort_pend;
`ifdef UART_FRAME_CKSUM_EN
    logic [UART_DATA_W-1:0] r_sum;
`endif

    logic                   w_tx;
    logic                   w_ready;
    logic                   w_char_done;
    logic                   w_abort;
    logic                   w_last;
    logic [UART_DATA_W-1:0] w_pix_byte;
    logic                   w_unused;

    assign w_abort    = r_abort_pend | abort;
    assign w_last     = (r_count == FRAME_BYTES - 20'd1);
    assign w_pix_byte = pix_data[PIX_BYTE_MSB:PIX_BYTE_LSB];
    assign w_unused   = ^pix_data[PIX_BYTE_LSB-1:0];

    uart_tx_serializer #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (r_load),
        .data      (r_data),
        .tx        (w_tx),
        .ready     (w_ready),
        .char_done (w_char_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pix_rd     <= 1'b0;
            r_load       <= 1'b0;
            r_data       <= '0;
            r_count      <= '0;
            r_abort_pend <= 1'b0;
`ifdef UART_FRAME_CKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            r_load   <= 1'b0;
            r_pix_rd <= 1'b0;
            r_done   <= 1'b0;
            if (abort && r_state != IDLE) begin
                r_abort_pend <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    r_abort_pend <= 1'b0;
                    if (start && !abort && w_ready) begin
                        r_state <= HDR0;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                        r_load  <= 1'b1;
                        r_data  <= SYNC_WORD[15:8];
`ifdef UART_FRAME_CKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end
                HDR0: begin
                    if (w_char_done) begin
                        if (w_abort) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= HDR1;
                            r_load  <= 1'b1;
                            r_data  <= SYNC_WORD[7:0];
                        end
                    end
                end
                HDR1: begin
                    if (w_char_done) begin
                        if (w_abort) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state  <= FETCH;
                            r_pix_rd <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    // pix_data is valid now, one cycle after the read strobe.
                    r_state <= SEND;
                    r_load  <= 1'b1;
                    r_data  <= w_pix_byte;
`ifdef UART_FRAME_CKSUM_EN
                    r_sum   <= r_sum + w_pix_byte;
`endif
                end
                SEND: begin
                    if (w_char_done) begin
                        r_count <= r_count + 20'd1;
                        if (w_abort) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else if (w_last) begin
`ifdef UART_FRAME_CKSUM_EN
                            r_state <= CKSUM;
                            r_load  <= 1'b1;
                            r_data  <= cksum_trailer(r_sum);
`else
                            r_state <= DONE;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_state  <= FETCH;
                            r_pix_rd <= 1'b1;
                        end
                    end
                end
`ifdef UART_FRAME_CKSUM_EN
                CKSUM: begin
                    if (w_char_done) begin
                        if (w_abort) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx         = w_tx;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pix_rd     = r_pix_rd;
    assign byte_count = r_count;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx with BIT_CYC=16 and a 4-byte frame.
// Build with +define+UART_FRAME_CKSUM_EN to check the checksum trailer.
module tb_uart_frame_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        pix_rd;
    logic [11:0] pix_data = 12'h000;
    logic        tx;
    logic        busy;
    logic        done;
    logic [19:0] byte_count;

    int n_chk = 0;
    int n_err = 0;

    int rd_cnt = 0;
    int rd_base = 0;
    int done_cnt = 0;
    int frame_err = 0;
    logic [7:0] rx_q[$];

    logic [11:0] vec [4] = '{12'hAB0, 12'h120, 12'hFF0, 12'h010};
`ifdef UART_FRAME_CKSUM_EN
    localparam int NEXP = 7;
    logic [7:0] exp_b [NEXP] = '{8'hA5, 8'h5A, 8'hAB, 8'h12, 8'hFF, 8'h01, 8'h43};
`else
    localparam int NEXP = 6;
    logic [7:0] exp_b [NEXP] = '{8'hA5, 8'h5A, 8'hAB, 8'h12, 8'hFF, 8'h01};
`endif

    uart_frame_tx #(
        .CLK_FREQ    (16),
        .UART_BPS    (1),
        .FRAME_BYTES (20'd4),
        .SYNC_WORD   (16'hA55A)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .pix_rd     (pix_rd),
        .pix_data   (pix_data),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    // RD2 FIFO model: data appears the cycle after the strobe.
    always @(negedge clk) begin
        if (pix_rd === 1'b1) begin
            pix_data = vec[(rd_cnt - rd_base) % 4];
            rd_cnt++;
        end
        if (done === 1'b1) done_cnt++;
    end

    // UART line decoder, samples at mid-bit.
    initial begin
        logic [7:0] b;
        bit bad;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                repeat (8) @(negedge clk);
                bad = (tx !== 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    b[i] = tx;
                end
                repeat (16) @(negedge clk);
                if (tx !== 1'b1) bad = 1'b1;
                if (bad) frame_err++;
                rx_q.push_back(b);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (tx === lvl && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int k = 0;
        while (busy !== 1'b0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_count(input string tag, input logic [19:0] n,
                              input int lim);
        int k = 0;
        while (byte_count !== n && k < lim) begin
            @(negedge clk);
            k++;
        end
        check(tag, {12'd0, byte_count}, {12'd0, n});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int qb);
        int n;
        n = rx_q.size() - qb;
        check({tag, "_nbytes"}, n, NEXP);
        for (int i = 0; i < n && i < NEXP; i++) begin
            check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[qb + i]},
                  {24'd0, exp_b[i]});
        end
    endtask

    initial begin
        int n;
        int qb;
        int db;
        int fb;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pix_rd", {31'd0, pix_rd}, 32'd0);
        check("rst_byte_count", {12'd0, byte_count}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal frame with latency and bit timing.
        qb = rx_q.size(); db = done_cnt; rd_base = rd_cnt; fb = frame_err;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("lat_edge1_tx", {31'd0, tx}, 32'd1);
        check("lat_edge1_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check("lat_edge2_tx", {31'd0, tx}, 32'd0);
        run_len(1'b0, n);
        check("bit_start_len", n, 16);
        run_len(1'b1, n);
        check("bit_d0_len", n, 16);
        run_len(1'b0, n);
        check("bit_d1_len", n, 16);
        wait_idle("t1_idle", 3000);
        repeat (4) @(negedge clk);
        check_frame("t1", qb);
        check("t1_pix_rd", rd_cnt - rd_base, 4);
        check("t1_done", done_cnt - db, 1);
        check("t1_byte_count", {12'd0, byte_count}, 32'd4);
        check("t1_frame_err", frame_err - fb, 0);

        // Abort during payload byte 2.
        qb = rx_q.size(); db = done_cnt; rd_base = rd_cnt; fb = frame_err;
        pulse_start();
        wait_count("t3_byte1", 20'd1, 2000);
        repeat (40) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t3_busy_mid", {31'd0, busy}, 32'd1);
        wait_idle("t3_idle", 400);
        check("t3_tx_high", {31'd0, tx}, 32'd1);
        repeat (300) @(negedge clk);
        check("t3_byte_count", {12'd0, byte_count}, 32'd2);
        check("t3_pix_rd", rd_cnt - rd_base, 2);
        check("t3_done", done_cnt - db, 0);
        check("t3_nbytes", rx_q.size() - qb, 4);
        if (rx_q.size() - qb == 4)
            check("t3_last_byte", {24'd0, rx_q[qb + 3]}, 32'h12);
        check("t3_frame_err", frame_err - fb, 0);

        // Start while busy is ignored.
        qb = rx_q.size(); db = done_cnt; rd_base = rd_cnt;
        pulse_start();
        repeat (100) @(negedge clk);
        pulse_start();
        wait_idle("t4_idle", 3000);
        repeat (400) @(negedge clk);
        check_frame("t4", qb);
        check("t4_pix_rd", rd_cnt - rd_base, 4);
        check("t4_done", done_cnt - db, 1);

        // start and abort together in IDLE are ignored.
        qb = rx_q.size(); rd_base = rd_cnt;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("t4b_busy", {31'd0, busy}, 32'd0);
        repeat (200) @(negedge clk);
        check("t4b_nbytes", rx_q.size() - qb, 0);
        check("t4b_pix_rd", rd_cnt - rd_base, 0);
        check("t4b_byte_count", {12'd0, byte_count}, 32'd4);

        // One-cycle reset mid-character.
        rd_base = rd_cnt;
        pulse_start();
        wait_count("t5_byte1", 20'd1, 2000);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t5_rst_tx", {31'd0, tx}, 32'd1);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_byte_count", {12'd0, byte_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        qb = rx_q.size(); db = done_cnt; rd_base = rd_cnt; fb = frame_err;
        pulse_start();
        wait_idle("t5_idle", 3000);
        repeat (4) @(negedge clk);
        check_frame("t5", qb);
        check("t5_done", done_cnt - db, 1);
        check("t5_byte_count", {12'd0, byte_count}, 32'd4);
        check("t5_frame_err", frame_err - fb, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
